// File: rtl/pipe_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM state encoding and state-class helper.
package pipe_run_ctrl_pkg;

  typedef enum logic [2:0] {
    RS_HOLD  = 3'd0,
    RS_IDLE  = 3'd1,
    RS_RUN   = 3'd2,
    RS_DRAIN = 3'd3,
    RS_DONE  = 3'd4
  } run_state_t;

  // RUN and DRAIN are the states that accumulate cycles and retirements.
  function automatic logic is_active(run_state_t s);
    return (s == RS_RUN) || (s == RS_DRAIN);
  endfunction

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// Control/status bundle between the board-level driver and the run controller.
interface pipe_run_ctrl_if #(
  parameter int CNT_W = 32
);
  // Every signal is sampled on the rising clock edge. start, clear and wb_valid
  // are single-cycle qualifiers with no backpressure: each cycle they are high
  // counts as one event, and the controller never stalls the sender.
  logic             start;
  logic             clear;
  logic [CNT_W-1:0] instr_budget;
  logic             stall;
  logic             wb_valid;
  logic             core_reset;
  logic             fetch_en;
  logic             running;
  logic             done;
  logic             timeout;
  logic             drain_err;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output start, clear, instr_budget, stall, wb_valid,
    input  core_reset, fetch_en, running, done, timeout, drain_err,
    input  cycle_count, issue_count, retire_count
  );

  modport slave (
    input  start, clear, instr_budget, stall, wb_valid,
    output core_reset, fetch_en, running, done, timeout, drain_err,
    output cycle_count, issue_count, retire_count
  );
endinterface

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_run_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller for the 5-stage core: reset sequencing, budgeted fetch gating,
// pipeline drain supervision and cycle/issue/retire accounting. All outputs registered.
module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int PIPELINE_DEPTH    = 5,
  parameter int CNT_W             = 32,
  parameter int MAX_CYCLES        = 4096,
  parameter bit AUTO_START        = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  pipe_run_ctrl_if.slave bus,
  output run_state_t     state_o
);
  localparam int HOLD_W  = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int DRAIN_W = (PIPELINE_DEPTH > 1) ? $clog2(PIPELINE_DEPTH) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPELINE_DEPTH - 1);
  localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(MAX_CYCLES - 1);

  typedef struct packed {
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] issue;
    logic [CNT_W-1:0] retire;
  } run_stat_t;

  run_state_t         state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic               core_reset_q, core_reset_d;
  logic               fetch_en_q, fetch_en_d;
  logic               running_q, running_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               drain_err_q, drain_err_d;

  run_stat_t          stat;
  logic               active;
  logic               issue_inc;
  logic               retire_inc;
  logic               cyc_last;
  logic [CNT_W-1:0]   retire_nx;
  logic [CNT_W:0]     issue_nx;

  assign active     = is_active(state_q);
  assign issue_inc  = (state_q == RS_RUN) && fetch_en_q && !bus.stall;
  assign retire_inc = active && bus.wb_valid;
  assign cyc_last   = (stat.cycle == CYC_LAST);
  // Retire value after this edge, so a write-back landing in the final drain
  // cycle still counts as a clean drain.
  assign retire_nx  = (retire_inc && (stat.retire != {CNT_W{1'b1}}))
                      ? stat.retire + CNT_W'(1) : stat.retire;
  assign issue_nx   = {1'b0, stat.issue} + (CNT_W + 1)'(issue_inc);

  pipe_run_ctrl_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(reset), .clr_i(bus.clear), .inc_i(active), .q_o(stat.cycle)
  );
  pipe_run_ctrl_sat_counter #(.W(CNT_W)) u_issue_cnt (
    .clk(clk), .rst_n(reset), .clr_i(bus.clear), .inc_i(issue_inc), .q_o(stat.issue)
  );
  pipe_run_ctrl_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .rst_n(reset), .clr_i(bus.clear), .inc_i(retire_inc), .q_o(stat.retire)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    drain_cnt_d = '0;
    budget_d    = budget_q;
    timeout_d   = timeout_q;
    drain_err_d = drain_err_q;

    if (bus.clear) begin
      state_d     = RS_HOLD;
      hold_cnt_d  = '0;
      budget_d    = '0;
      timeout_d   = 1'b0;
      drain_err_d = 1'b0;
    end else begin
      unique case (state_q)
        RS_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            if (AUTO_START) begin
              state_d  = RS_RUN;
              budget_d = bus.instr_budget;
            end else begin
              state_d = RS_IDLE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        RS_IDLE: begin
          if (bus.start) begin
            state_d  = RS_RUN;
            budget_d = bus.instr_budget;
          end
        end
        RS_RUN: begin
          if (cyc_last) begin
            state_d   = RS_DONE;
            timeout_d = 1'b1;
          end else if (stat.issue >= budget_q) begin
            state_d = RS_DRAIN;
          end
        end
        RS_DRAIN: begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
          if (cyc_last) begin
            state_d   = RS_DONE;
            timeout_d = 1'b1;
          end else if (retire_nx == stat.issue) begin
            state_d = RS_DONE;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = RS_DONE;
            drain_err_d = 1'b1;
          end
        end
        RS_DONE: begin
          state_d = RS_DONE;
        end
        default: begin
          state_d = RS_HOLD;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    core_reset_d = (state_d == RS_HOLD);
    running_d    = is_active(state_d);
    done_d       = (state_d == RS_DONE);
    fetch_en_d   = (state_d == RS_RUN) && (issue_nx < {1'b0, budget_d});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RS_HOLD;
      hold_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      budget_q     <= '0;
      core_reset_q <= 1'b1;
      fetch_en_q   <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      drain_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      budget_q     <= budget_d;
      core_reset_q <= core_reset_d;
      fetch_en_q   <= fetch_en_d;
      running_q    <= running_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      drain_err_q  <= drain_err_d;
    end
  end

  assign bus.core_reset   = core_reset_q;
  assign bus.fetch_en     = fetch_en_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.timeout      = timeout_q;
  assign bus.drain_err    = drain_err_q;
  assign bus.cycle_count  = stat.cycle;
  assign bus.issue_count  = stat.issue;
  assign bus.retire_count = stat.retire;
  assign state_o          = state_q;
endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: whole-run vector table plus clear/reset/start sequences.
`timescale 1ns/1ps
module tb_pipe_run_ctrl;
  import pipe_run_ctrl_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  run_state_t state_a;
  run_state_t state_b;

  pipe_run_ctrl_if #(.CNT_W(32)) bus ();
  pipe_run_ctrl_if #(.CNT_W(32)) bus_b ();

  pipe_run_ctrl #(
    .RESET_HOLD_CYCLES(2), .PIPELINE_DEPTH(5), .CNT_W(32),
    .MAX_CYCLES(64), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_o(state_a)
  );

  pipe_run_ctrl #(
    .RESET_HOLD_CYCLES(2), .PIPELINE_DEPTH(5), .CNT_W(32),
    .MAX_CYCLES(64), .AUTO_START(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .state_o(state_b)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] pipe_sr  = '0;
  bit         core_model_en = 1'b0;

  typedef struct {
    logic [31:0] budget;
    logic [7:0]  stall_mask;
    bit          wb_en;
    logic [31:0] exp_issue;
    logic [31:0] exp_retire;
    logic [31:0] exp_cycle;
    bit          exp_timeout;
    bit          exp_drain_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock; the core model retires each issue 4 cycles later and is flushed
  // while core_reset is high.
  task automatic tick();
    logic issued;
    issued = bus.fetch_en && !bus.stall;
    @(posedge clk);
    #1;
    if (bus.core_reset) pipe_sr = '0;
    else pipe_sr = {pipe_sr[2:0], issued};
    bus.wb_valid = core_model_en && pipe_sr[3];
  endtask

  task automatic zero_inputs();
    bus.start = 1'b0;   bus.clear = 1'b0;   bus.instr_budget = '0;
    bus.stall = 1'b0;   bus.wb_valid = 1'b0;
    bus_b.start = 1'b0; bus_b.clear = 1'b0; bus_b.instr_budget = '0;
    bus_b.stall = 1'b0; bus_b.wb_valid = 1'b0;
    pipe_sr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    zero_inputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Cycle 0/1 after reset release (or clear) are HOLD; RUN starts at cycle 2.
  task automatic run_until_done(input logic [31:0] budget, input logic [7:0] mask,
                                output bit over, output bit hit);
    logic [31:0] issued;
    issued = '0;
    over = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.done) begin
        hit = 1'b1;
        break;
      end
      bus.stall = 1'b0;
      if (c >= 2 && c < 10) bus.stall = mask[c-2];
      if (c < 2) chk("core_reset_hold", bus.core_reset, 1);
      if (c == 2) begin
        chk("core_reset_drop", bus.core_reset, 0);
        chk("running_in_run", bus.running, 1);
      end
      if (bus.fetch_en && issued >= budget) over = 1'b1;
      if (bus.fetch_en && !bus.stall) issued++;
      tick();
    end
    bus.stall = 1'b0;
  endtask

  initial begin
    bit over, hit;

    //      budget  stall     wb    issue  retire cycle  tmo   derr
    vecs[0] = '{32'd8,    8'h00, 1'b1, 32'd8,  32'd8,  32'd12, 1'b0, 1'b0};
    vecs[1] = '{32'd5,    8'h1a, 1'b1, 32'd5,  32'd5,  32'd12, 1'b0, 1'b0};
    vecs[2] = '{32'd0,    8'h00, 1'b1, 32'd0,  32'd0,  32'd2,  1'b0, 1'b0};
    vecs[3] = '{32'd8,    8'h00, 1'b0, 32'd8,  32'd0,  32'd14, 1'b0, 1'b1};
    vecs[4] = '{32'd1000, 8'h00, 1'b1, 32'd64, 32'd60, 32'd64, 1'b1, 1'b0};
    vecs[5] = '{32'd1,    8'h00, 1'b1, 32'd1,  32'd1,  32'd5,  1'b0, 1'b0};

    // Reset values
    reset = 1'b0;
    zero_inputs();
    @(posedge clk);
    #1;
    chk("rst_state", state_a, RS_HOLD);
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_fetch_en", bus.fetch_en, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flags", {bus.timeout, bus.drain_err}, 0);
    chk("rst_counts", bus.cycle_count | bus.issue_count | bus.retire_count, 0);
    chk("rst_state_b", state_b, RS_HOLD);

    // Whole-run vectors
    foreach (vecs[i]) begin
      do_reset();
      bus.instr_budget = vecs[i].budget;
      core_model_en = vecs[i].wb_en;
      run_until_done(vecs[i].budget, vecs[i].stall_mask, over, hit);
      chk($sformatf("v%0d_done", i), hit, 1);
      chk($sformatf("v%0d_state", i), state_a, RS_DONE);
      chk($sformatf("v%0d_issue", i), bus.issue_count, vecs[i].exp_issue);
      chk($sformatf("v%0d_retire", i), bus.retire_count, vecs[i].exp_retire);
      chk($sformatf("v%0d_cycle", i), bus.cycle_count, vecs[i].exp_cycle);
      chk($sformatf("v%0d_timeout", i), bus.timeout, vecs[i].exp_timeout);
      chk($sformatf("v%0d_drain_err", i), bus.drain_err, vecs[i].exp_drain_err);
      chk($sformatf("v%0d_fetch_over_budget", i), over, 0);
      chk($sformatf("v%0d_outs_low", i), {bus.fetch_en, bus.core_reset, bus.running}, 0);
      core_model_en = 1'b0;
      bus.wb_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.wb_valid = 1'b0;
      chk($sformatf("v%0d_done_sticky", i), bus.done, 1);
      chk($sformatf("v%0d_cycle_frozen", i), bus.cycle_count, vecs[i].exp_cycle);
      chk($sformatf("v%0d_retire_frozen", i), bus.retire_count, vecs[i].exp_retire);
    end

    // Clear mid-RUN, then rerun
    do_reset();
    bus.instr_budget = 32'd8;
    core_model_en = 1'b1;
    repeat (5) tick();
    chk("clr_pre_state", state_a, RS_RUN);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_state", state_a, RS_HOLD);
    chk("clr_core_reset", bus.core_reset, 1);
    chk("clr_outs_low", {bus.fetch_en, bus.running, bus.done}, 0);
    chk("clr_counts", bus.cycle_count | bus.issue_count | bus.retire_count, 0);
    run_until_done(32'd8, 8'h00, over, hit);
    chk("clr_rerun_done", hit, 1);
    chk("clr_rerun_issue", bus.issue_count, 8);
    chk("clr_rerun_retire", bus.retire_count, 8);
    chk("clr_rerun_cycle", bus.cycle_count, 12);
    chk("clr_rerun_drain_err", bus.drain_err, 0);

    // Asynchronous reset in the middle of DRAIN
    do_reset();
    bus.instr_budget = 32'd8;
    core_model_en = 1'b0;
    repeat (13) tick();
    chk("arst_pre_state", state_a, RS_DRAIN);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", state_a, RS_HOLD);
    chk("arst_core_reset", bus.core_reset, 1);
    chk("arst_outs_low", {bus.fetch_en, bus.running, bus.done, bus.drain_err}, 0);
    chk("arst_counts", bus.cycle_count | bus.issue_count | bus.retire_count, 0);

    // AUTO_START=0: park in IDLE until start
    do_reset();
    bus_b.instr_budget = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_state", state_b, RS_IDLE);
    chk("idle_outs_low", {bus_b.core_reset, bus_b.fetch_en, bus_b.running}, 0);
    bus_b.wb_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus_b.wb_valid = 1'b0;
    chk("idle_wait_state", state_b, RS_IDLE);
    chk("idle_no_fetch", bus_b.fetch_en, 0);
    chk("idle_counts", bus_b.retire_count | bus_b.cycle_count, 0);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    chk("start_running", bus_b.running, 1);
    chk("start_fetch_en", bus_b.fetch_en, 1);
    hit = 1'b0;
    for (int b = 0; b < 40; b++) begin
      if (bus_b.done) begin
        hit = 1'b1;
        break;
      end
      bus_b.wb_valid = (b == 2 || b == 3);
      @(posedge clk);
      #1;
    end
    bus_b.wb_valid = 1'b0;
    chk("start_done", hit, 1);
    chk("start_issue", bus_b.issue_count, 2);
    chk("start_retire", bus_b.retire_count, 2);
    chk("start_cycle", bus_b.cycle_count, 4);
    chk("start_drain_err", bus_b.drain_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
